// File: rtl/cla_pipe_addsub_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the ALU adders:
//   - op encoding (OP_ADD / OP_SUB)
//   - segment width and group count helpers
//   - the generate/propagate pair and its associative combine operator
// Ports: none (package).
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Generate / propagate pair for a bit or a group of bits.
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Identity element of gp_combine: an empty span generates nothing and
    // propagates everything.
    localparam gp_t GP_IDENT = '{g: 1'b0, p: 1'b1};

    function automatic int seg_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic int grp_count(input int seg_w, input int grp);
        return seg_w / grp;
    endfunction

    // Combine a more-significant span (hi) with the adjacent less-significant
    // span (lo) into the P/G of the concatenated span.
    function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/cla_pipe_addsub_if.sv
// -----------------------------------------------------------------------------
// cla_pipe_addsub_if
// Operand/result handshake bundle for cla_pipe_addsub.
//   in_valid/in_ready   : operand beat handshake (a, b, op, sat)
//   out_valid/out_ready : result beat handshake (sum, carry, overflow, zero)
// Modports:
//   master : the operand source / result sink (drives operands and out_ready)
//   slave  : the adder itself
// WIDTH must match the WIDTH of the adder it is connected to.
// -----------------------------------------------------------------------------
interface cla_pipe_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op;
    logic             sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, op, sat, out_ready,
        input  in_ready, out_valid, sum, carry, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, op, sat, out_ready,
        output in_ready, out_valid, sum, carry, overflow, zero
    );
endinterface

// File: rtl/cla_pipe_addsub_cla_seg.sv
// -----------------------------------------------------------------------------
// cla_seg
// Combinational SEG_W-bit two-level carry-lookahead adder segment.
// Bit P/G fold into group P/G (GRP bits each); group P/G feed a second-level
// lookahead that produces every group carry-in directly from cin_i, so no
// carry ripples from one group to the next.
// Ports:
//   a_i, b_i  in  SEG_W  operands (b_i already inverted for subtract)
//   cin_i     in  1      segment carry-in
//   s_o       out SEG_W  segment sum
//   cout_o    out 1      segment carry-out
// -----------------------------------------------------------------------------
module cla_seg
    import adder_pkg::*;
#(
    parameter int SEG_W = 16,
    parameter int GRP   = 4
) (
    input  logic [SEG_W-1:0] a_i,
    input  logic [SEG_W-1:0] b_i,
    input  logic             cin_i,
    output logic [SEG_W-1:0] s_o,
    output logic             cout_o
);
    localparam int NGRP = grp_count(SEG_W, GRP);

    gp_t             bit_gp [SEG_W];
    gp_t             grp_gp [NGRP];
    logic [NGRP:0]   grp_c;

    always_comb begin
        gp_t acc;
        gp_t pre;
        // NOTE: every output of this block gets a value before any branch or
        // loop touches it, so no path leaves a signal unassigned (no latch).
        s_o   = '0;
        grp_c = '0;
        acc   = GP_IDENT;
        pre   = GP_IDENT;

        for (int i = 0; i < SEG_W; i++) begin
            bit_gp[i].g = a_i[i] & b_i[i];
            bit_gp[i].p = a_i[i] ^ b_i[i];
        end

        // First level: group P/G.
        for (int k = 0; k < NGRP; k++) begin
            acc = GP_IDENT;
            for (int j = 0; j < GRP; j++) begin
                acc = gp_combine(bit_gp[k*GRP + j], acc);
            end
            grp_gp[k] = acc;
        end

        // Second level: each group carry-in is a prefix of group P/G applied
        // to the segment carry-in.
        grp_c[0] = cin_i;
        pre      = GP_IDENT;
        for (int k = 0; k < NGRP; k++) begin
            pre          = gp_combine(grp_gp[k], pre);
            grp_c[k + 1] = pre.g | (pre.p & cin_i);
        end

        // Bit carries inside each group come from that group's carry-in.
        for (int k = 0; k < NGRP; k++) begin
            pre = GP_IDENT;
            for (int j = 0; j < GRP; j++) begin
                s_o[k*GRP + j] = bit_gp[k*GRP + j].p ^ (pre.g | (pre.p & grp_c[k]));
                pre            = gp_combine(bit_gp[k*GRP + j], pre);
            end
        end

        cout_o = grp_c[NGRP];
    end

endmodule

// File: rtl/cla_pipe_addsub.sv
// -----------------------------------------------------------------------------
// cla_pipe_addsub
// Pipelined carry-lookahead adder/subtractor. The operand is split into
// STAGES segments of SEG_W = WIDTH/STAGES bits; stage k sums segment k from
// the carry registered by stage k-1. Upper operand bits, op (and sat) travel
// down the pipe with the lower sum bits already computed. The last stage
// register is the output register and also holds the status flags.
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of cla_pipe_addsub_if:
//          in_valid/in_ready, a, b, op (0 add, 1 subtract), sat,
//          out_valid/out_ready, sum, carry, overflow, zero
// Parameters: WIDTH (multiple of STAGES*GRP), GRP, STAGES.
// Build option: define ADDER_SAT_EN to clamp signed overflow when sat=1;
// otherwise sat is ignored and results wrap modulo 2^WIDTH.
// -----------------------------------------------------------------------------
module cla_pipe_addsub
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int GRP    = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    cla_pipe_addsub_if.slave bus
);
    localparam int SEG_W = seg_width(WIDTH, STAGES);
    localparam int LAST  = STAGES - 1;
    // Skew registers sit between stages; keep one entry even for STAGES=1.
    localparam int NSKEW = (STAGES > 1) ? STAGES - 1 : 1;

    // Per-stage inputs (stage 0 from the bus, stage k from skew regs k-1).
    logic [STAGES-1:0] src_vld;
    logic [STAGES-1:0] src_op;
    logic [STAGES-1:0] src_cin;
    logic [STAGES-1:0] seg_cout;
    logic [STAGES-1:0] stage_vld;
    logic [STAGES-1:0] load;
    logic [WIDTH-1:0]  src_a   [STAGES];
    logic [WIDTH-1:0]  src_b   [STAGES];
    logic [WIDTH-1:0]  src_sum [STAGES];
    logic [WIDTH-1:0]  new_sum [STAGES];
    logic [SEG_W-1:0]  seg_s   [STAGES];

    // Skew registers between stages.
    logic [NSKEW-1:0]  vld_q;
    logic [NSKEW-1:0]  op_q;
    logic [NSKEW-1:0]  c_q;
    logic [WIDTH-1:0]  a_q    [NSKEW];
    logic [WIDTH-1:0]  b_q    [NSKEW];
    logic [WIDTH-1:0]  psum_q [NSKEW];

    // Output stage registers.
    logic              out_valid_q;
    logic [WIDTH-1:0]  res_q;
    logic              carry_q;
    logic              ovf_q;
    logic              zero_q;

    logic [WIDTH-1:0]  fin_sum;
    logic              fin_ovf;

`ifdef ADDER_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    logic [STAGES-1:0] src_sat;
    logic [NSKEW-1:0]  sat_q;
`else
    logic unused_sat;
    assign unused_sat = bus.sat;
`endif

    // Stage k loads unless it and every stage after it are full while the
    // sink is stalled. Closed form of the chained stall rule, loop-free.
    for (genvar k = 0; k < STAGES; k++) begin : g_load
        if (k == LAST) begin : g_last
            assign stage_vld[k] = out_valid_q;
        end else begin : g_mid
            assign stage_vld[k] = vld_q[k];
        end
        assign load[k] = bus.out_ready | ~(&stage_vld[LAST:k]);
    end

    assign bus.in_ready = load[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign src_vld[0] = bus.in_valid;
            assign src_a[0]   = bus.a;
            assign src_b[0]   = bus.b;
            assign src_op[0]  = bus.op;
            assign src_cin[0] = (bus.op == OP_SUB);
            assign src_sum[0] = '0;
`ifdef ADDER_SAT_EN
            assign src_sat[0] = bus.sat;
`endif
        end else begin : g_body
            logic unused_lo;
            assign src_vld[k] = vld_q[k-1];
            assign src_a[k]   = a_q[k-1];
            assign src_b[k]   = b_q[k-1];
            assign src_op[k]  = op_q[k-1];
            assign src_cin[k] = c_q[k-1];
            assign src_sum[k] = psum_q[k-1];
`ifdef ADDER_SAT_EN
            assign src_sat[k] = sat_q[k-1];
`endif
            // Operand bits below this segment were consumed upstream.
            assign unused_lo = ^{src_a[k][k*SEG_W-1:0], src_b[k][k*SEG_W-1:0]};
        end

        cla_seg #(
            .SEG_W (SEG_W),
            .GRP   (GRP)
        ) u_seg (
            .a_i    (src_a[k][k*SEG_W +: SEG_W]),
            .b_i    (src_b[k][k*SEG_W +: SEG_W] ^ {SEG_W{src_op[k]}}),
            .cin_i  (src_cin[k]),
            .s_o    (seg_s[k]),
            .cout_o (seg_cout[k])
        );

        // Bits at and above segment k are still zero in src_sum, so OR-ing
        // the new segment in place is enough.
        assign new_sum[k] = src_sum[k] | (WIDTH'(seg_s[k]) << (k*SEG_W));
    end

    // Flags and optional clamp from the full result, in front of the
    // output register.
    always_comb begin
        fin_sum = new_sum[LAST];
        fin_ovf = (src_a[LAST][WIDTH-1] == (src_b[LAST][WIDTH-1] ^ src_op[LAST]))
                & (new_sum[LAST][WIDTH-1] != src_a[LAST][WIDTH-1]);
`ifdef ADDER_SAT_EN
        if (src_sat[LAST] && fin_ovf) begin
            fin_sum = src_a[LAST][WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: data registers are cleared along with the valid bits so
            // the outputs read all-zero during and right after reset.
            vld_q       <= '0;
            op_q        <= '0;
            c_q         <= '0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
`ifdef ADDER_SAT_EN
            sat_q       <= '0;
`endif
            for (int k = 0; k < NSKEW; k++) begin
                a_q[k]    <= '0;
                b_q[k]    <= '0;
                psum_q[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage sample the
            // previous stage's old value on the same edge.
            for (int k = 0; k < LAST; k++) begin
                if (load[k]) begin
                    vld_q[k] <= src_vld[k];
                end
                // Data moves only with a real beat, so an empty stage keeps
                // its last contents.
                if (load[k] && src_vld[k]) begin
                    a_q[k]    <= src_a[k];
                    b_q[k]    <= src_b[k];
                    op_q[k]   <= src_op[k];
                    c_q[k]    <= seg_cout[k];
                    psum_q[k] <= new_sum[k];
`ifdef ADDER_SAT_EN
                    sat_q[k]  <= src_sat[k];
`endif
                end
            end
            if (load[LAST]) begin
                out_valid_q <= src_vld[LAST];
            end
            if (load[LAST] && src_vld[LAST]) begin
                res_q   <= fin_sum;
                carry_q <= seg_cout[LAST];
                ovf_q   <= fin_ovf;
                zero_q  <= ~|fin_sum;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = res_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;

endmodule
